// File: rtl/logic_ops_pkg.sv
// Shared op-code encoding and result-flag type for the pipelined logic unit.
package logic_ops_pkg;
  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_AND   = 3'b000;
  localparam op_t OP_OR    = 3'b001;
  localparam op_t OP_XOR   = 3'b010;
  localparam op_t OP_NOR   = 3'b011;
  localparam op_t OP_ANDN  = 3'b100;
  localparam op_t OP_ORN   = 3'b101;
  localparam op_t OP_XNOR  = 3'b110;
  localparam op_t OP_PASSA = 3'b111;

  typedef struct packed {
    logic zero;
    logic ones;
    logic parity;
  } flags_t;

  // Value the flags take while no valid result has been produced since reset.
  localparam flags_t FLAGS_RST = '{zero: 1'b1, ones: 1'b0, parity: 1'b0};
endpackage

// File: rtl/logic_op_comb.sv
// Purely combinational WIDTH-bit logic function, selected by a 3-bit op code.
module logic_op_comb
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z
);
  always_comb begin
    z = a;
    case (op)
      OP_AND:   z = a & b;
      OP_OR:    z = a | b;
      OP_XOR:   z = a ^ b;
      OP_NOR:   z = ~(a | b);
      OP_ANDN:  z = a & ~b;
      OP_ORN:   z = a | ~b;
      OP_XNOR:  z = ~(a ^ b);
      OP_PASSA: z = a;
      default:  z = a;
    endcase
  end
endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined logic unit: s1 holds operands, s2 holds the
// result and its flags. in_ready is the only combinational path (from out_ready).
module logic_unit_pipe
  import logic_ops_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_zero,
  output logic             out_ones,
  output logic             out_parity
);
  logic             s1_valid_q, s1_valid_d;
  op_t              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_z_q, s2_z_d;
  flags_t           s2_flags_q, s2_flags_d;

  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] alu_z;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  logic_op_comb #(.WIDTH(WIDTH)) u_op (
    .op (s1_op_q),
    .a  (s1_a_q),
    .b  (s1_b_q),
    .z  (alu_z)
  );

  // Data registers only load on advance with valid data so idle cycles do not toggle them.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_op_d    = s1_op_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d = in_op;
        s1_a_d  = in_a;
        s1_b_d  = in_b;
      end
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_z_d     = s2_z_q;
    s2_flags_d = s2_flags_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_z_d            = alu_z;
        s2_flags_d.zero   = ~|alu_z;
        s2_flags_d.ones   = &alu_z;
        s2_flags_d.parity = ^alu_z;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= OP_AND;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_z_q     <= '0;
      s2_flags_q <= FLAGS_RST;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_op_q    <= s1_op_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s2_valid_q <= s2_valid_d;
      s2_z_q     <= s2_z_d;
      s2_flags_q <= s2_flags_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_z      = s2_z_q;
  assign out_zero   = s2_flags_q.zero;
  assign out_ones   = s2_flags_q.ones;
  assign out_parity = s2_flags_q.parity;
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench: WIDTH=8 instance for flow/flag scenarios, WIDTH=1 and
// WIDTH=64 instances for the parametric sweep, all on one clock and reset.
module tb_logic_unit_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic       in_valid, in_ready, out_valid, out_ready, out_zero, out_ones, out_parity;
  logic [7:0] in_a, in_b, out_z;
  logic [2:0] in_op;

  logic       w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready, w1_out_zero, w1_out_ones, w1_out_parity;
  logic [0:0] w1_in_a, w1_in_b, w1_out_z;
  logic [2:0] w1_in_op;

  logic        w64_in_valid, w64_in_ready, w64_out_valid, w64_out_ready, w64_out_zero, w64_out_ones, w64_out_parity;
  logic [63:0] w64_in_a, w64_in_b, w64_out_z;
  logic [2:0]  w64_in_op;

  logic_unit_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_z(out_z), .out_zero(out_zero),
    .out_ones(out_ones), .out_parity(out_parity)
  );

  logic_unit_pipe #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(w1_in_valid), .in_ready(w1_in_ready),
    .in_a(w1_in_a), .in_b(w1_in_b), .in_op(w1_in_op), .out_valid(w1_out_valid),
    .out_ready(w1_out_ready), .out_z(w1_out_z), .out_zero(w1_out_zero),
    .out_ones(w1_out_ones), .out_parity(w1_out_parity)
  );

  logic_unit_pipe #(.WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(w64_in_valid), .in_ready(w64_in_ready),
    .in_a(w64_in_a), .in_b(w64_in_b), .in_op(w64_in_op), .out_valid(w64_out_valid),
    .out_ready(w64_out_ready), .out_z(w64_out_z), .out_zero(w64_out_zero),
    .out_ones(w64_out_ones), .out_parity(w64_out_parity)
  );

  // Reference model: op table from the encoding list, truncated to w bits.
  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input int w);
    logic [63:0] r;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a | b);
      3'd4: r = a & ~b;
      3'd5: r = a | ~b;
      3'd6: r = ~(a ^ b);
      default: r = a;
    endcase
    return r & wmask(w);
  endfunction

  // {zero, ones, parity} expected for a w-bit result value.
  function automatic logic [2:0] ref_flags(input logic [63:0] z, input int w);
    logic zf, of, pf;
    zf = ((z & wmask(w)) == 64'd0);
    of = ((z & wmask(w)) == wmask(w));
    pf = (($countones(z & wmask(w)) % 2) == 1);
    return {zf, of, pf};
  endfunction

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic ordy);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = ordy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    @(negedge clk);
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_z !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out: valid=%b z=%h want valid=0 z=00", out_valid, out_z);
    end
    n_tests++;
    if ({out_zero, out_ones, out_parity} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 100", {out_zero, out_ones, out_parity});
    end
    n_tests++;
    if (w1_out_valid !== 1'b0 || w64_out_valid !== 1'b0 || w64_out_z !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_wide: w1_valid=%b w64_valid=%b w64_z=%h want 0 0 0",
               w1_out_valid, w64_out_valid, w64_out_z);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_stream();
    logic [7:0] exp_z [8];
    exp_z = '{8'h30, 8'hFC, 8'hCC, 8'h03, 8'hC0, 8'hF3, 8'h33, 8'hF0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i < 8) drive(1'b1, 8'hF0, 8'h3C, 3'(i), 1'b1);
      else       drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      #1;
      if (i < 8) begin
        n_tests++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready);
        end
      end
      n_tests++;
      if (i >= 2 && i < 10) begin
        if (out_valid !== 1'b1 || out_z !== exp_z[i-2]) begin
          n_fail++;
          $display("FAIL stream_out[%0d]: valid=%b z=%h want valid=1 z=%h",
                   i - 2, out_valid, out_z, exp_z[i-2]);
        end
      end else if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stream_idle[%0d]: valid=%b want 0", i, out_valid);
      end
    end
  endtask

  task automatic test_flags();
    logic [2:0] ops   [3];
    logic [7:0] as    [3];
    logic [7:0] bs    [3];
    logic [7:0] zs    [3];
    logic [2:0] fl    [3];
    ops = '{3'd2, 3'd3, 3'd7};
    as  = '{8'h55, 8'h00, 8'h01};
    bs  = '{8'h55, 8'h00, 8'hA7};
    zs  = '{8'h00, 8'hFF, 8'h01};
    fl  = '{3'b100, 3'b010, 3'b001};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, as[k], bs[k], ops[k], 1'b1);
      @(negedge clk);
      drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
      @(negedge clk);
      #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_z !== zs[k] ||
          {out_zero, out_ones, out_parity} !== fl[k]) begin
        n_fail++;
        $display("FAIL flags[%0d]: valid=%b z=%h zop=%b want valid=1 z=%h zop=%b", k,
                 out_valid, out_z, {out_zero, out_ones, out_parity}, zs[k], fl[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] a [3];
    logic [7:0] b [3];
    logic [2:0] op[3];
    logic [7:0] r [3];
    for (int k = 0; k < 3; k++) begin
      a[k] = 8'($urandom); b[k] = 8'($urandom); op[k] = 3'($urandom);
      r[k] = 8'(ref_op(op[k], 64'(a[k]), 64'(b[k]), 8));
    end
    @(negedge clk); drive(1'b1, a[0], b[0], op[0], 1'b0); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept0: in_ready=%b want 1", in_ready); end
    @(negedge clk); drive(1'b1, a[1], b[1], op[1], 1'b0); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept1: in_ready=%b want 1", in_ready); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); drive(1'b1, a[2], b[2], op[2], 1'b0); #1;
      n_tests++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_z !== r[0]) begin
        n_fail++;
        $display("FAIL bp_stall[%0d]: in_ready=%b valid=%b z=%h want 0 1 %h",
                 c, in_ready, out_valid, out_z, r[0]);
      end
    end
    @(negedge clk); drive(1'b1, a[2], b[2], op[2], 1'b1); #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_z !== r[0]) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b valid=%b z=%h want 1 1 %h", in_ready, out_valid, out_z, r[0]);
    end
    for (int k = 1; k < 3; k++) begin
      @(negedge clk); drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1); #1;
      n_tests++;
      if (out_valid !== 1'b1 || out_z !== r[k]) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: valid=%b z=%h want 1 %h", k, out_valid, out_z, r[k]);
      end
    end
    @(negedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: valid=%b want 0", out_valid); end
  endtask

  task automatic test_alternating();
    logic [7:0] q[$];
    logic [7:0] e;
    int sent = 0;
    int got  = 0;
    for (int cyc = 0; cyc < 1000 && got < 100; cyc++) begin
      @(negedge clk);
      drive(sent < 100, 8'($urandom), 8'($urandom), 3'($urandom), (cyc % 2) == 0);
      #1;
      if (out_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL alt_extra: unexpected output z=%h", out_z);
        end else begin
          e = q.pop_front();
          if (out_z !== e || {out_zero, out_ones, out_parity} !== ref_flags(64'(e), 8)) begin
            n_fail++;
            $display("FAIL alt_result[%0d]: z=%h zop=%b want z=%h zop=%b", got, out_z,
                     {out_zero, out_ones, out_parity}, e, ref_flags(64'(e), 8));
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(8'(ref_op(in_op, 64'(in_a), 64'(in_b), 8)));
        sent++;
      end
    end
    n_tests++;
    if (got != 100 || sent != 100 || q.size() != 0) begin
      n_fail++;
      $display("FAIL alt_count: sent=%0d got=%0d left=%0d want 100 100 0", sent, got, q.size());
    end
    @(negedge clk); drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
  endtask

  task automatic test_async_reset();
    logic [7:0] r;
    @(negedge clk); drive(1'b1, 8'hA5, 8'h0F, 3'd2, 1'b0);
    @(negedge clk); drive(1'b1, 8'h3C, 8'hFF, 3'd0, 1'b0);
    @(negedge clk); drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0); #1;
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ar_full: valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_z !== 8'h00 || {out_zero, out_ones, out_parity} !== 3'b100) begin
      n_fail++;
      $display("FAIL ar_immediate: valid=%b z=%h zop=%b want 0 00 100", out_valid, out_z,
               {out_zero, out_ones, out_parity});
    end
    @(negedge clk);
    rst = 1'b0;
    r = 8'(ref_op(3'd5, 64'h5A, 64'hF0, 8));
    drive(1'b1, 8'h5A, 8'hF0, 3'd5, 1'b1);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
    @(negedge clk); drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1); #1;
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_early: valid=%b want 0", out_valid); end
    @(negedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_z !== r) begin
      n_fail++;
      $display("FAIL ar_first: valid=%b z=%h want 1 %h", out_valid, out_z, r);
    end
  endtask

  task automatic test_sweep();
    logic [63:0] e1 [8];
    logic [63:0] e64[8];
    logic [63:0] a64, b64;
    logic        a1, b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 8) begin
        a1 = 1'($urandom); b1 = 1'($urandom);
        a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
        w1_in_valid = 1'b1; w1_in_a = a1; w1_in_b = b1; w1_in_op = 3'(i);
        w64_in_valid = 1'b1; w64_in_a = a64; w64_in_b = b64; w64_in_op = 3'(i);
        e1[i]  = ref_op(3'(i), 64'(a1), 64'(b1), 1);
        e64[i] = ref_op(3'(i), a64, b64, 64);
      end else begin
        w1_in_valid = 1'b0;
        w64_in_valid = 1'b0;
      end
      #1;
      if (i >= 2) begin
        n_tests++;
        if (w1_out_valid !== 1'b1 || 64'(w1_out_z) !== e1[i-2] ||
            {w1_out_zero, w1_out_ones, w1_out_parity} !== ref_flags(e1[i-2], 1)) begin
          n_fail++;
          $display("FAIL sweep_w1[op%0d]: valid=%b z=%b zop=%b want 1 %0h %b", i - 2, w1_out_valid,
                   w1_out_z, {w1_out_zero, w1_out_ones, w1_out_parity}, e1[i-2], ref_flags(e1[i-2], 1));
        end
        n_tests++;
        if (w64_out_valid !== 1'b1 || w64_out_z !== e64[i-2] ||
            {w64_out_zero, w64_out_ones, w64_out_parity} !== ref_flags(e64[i-2], 64)) begin
          n_fail++;
          $display("FAIL sweep_w64[op%0d]: valid=%b z=%h zop=%b want 1 %h %b", i - 2, w64_out_valid,
                   w64_out_z, {w64_out_zero, w64_out_ones, w64_out_parity}, e64[i-2], ref_flags(e64[i-2], 64));
        end
      end
    end
  endtask

  initial begin
    drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b1);
    w1_in_valid = 1'b0; w1_in_a = 1'b0; w1_in_b = 1'b0; w1_in_op = 3'd0; w1_out_ready = 1'b1;
    w64_in_valid = 1'b0; w64_in_a = '0; w64_in_b = '0; w64_in_op = 3'd0; w64_out_ready = 1'b1;
    test_reset();
    test_stream();
    test_flags();
    test_backpressure();
    test_alternating();
    test_async_reset();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, two-stage pipelined bitwise logic unit for the MIPS32 datapath. It replaces the fixed 8-bit AND with a WIDTH-bit unit selecting one of eight logic ops. It adds result flags and valid/ready flow control, so it can sit in the EX stage and tolerate stalls from MEM.

Parameters:
WIDTH, 32, operand/result width in bits (legal range 1..64)

Ports:
clk  input  1  rising-edge clock (the block's only clock)
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands and op present on the input
in_ready  output  1  block accepts the input this cycle
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_op  input  3  operation select (encoding in Behaviour)
out_valid  output  1  result present on the output
out_ready  input  1  consumer accepts the result this cycle
out_z  output  WIDTH  result
out_zero  output  1  out_z is all zeros
out_ones  output  1  out_z is all ones
out_parity  output  1  XOR-reduction of out_z

Behaviour:
- Op encoding:
  - 000 AND (a&b)
  - 001 OR
  - 010 XOR
  - 011 NOR
  - 100 ANDN (a&~b)
  - 101 ORN (a|~b)
  - 110 XNOR
  - 111 PASS_A (a)
- Stage 1 (s1): registers in_op, in_a and in_b on acceptance; s1_valid is set.
- Stage 2 (s2): registers the computed WIDTH-bit result plus the three flags, computed from s1 contents. Drives out_* directly from registers; no combinational path from in_a/in_b to outputs.
- Transfers:
  - Input transfer: in_valid && in_ready at a rising edge.
  - Output transfer: out_valid && out_ready at a rising edge.
- Advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv. This is combinational from out_ready and is the only comb path through the block.
- Latency:
  - A transfer accepted at edge N gives out_valid=1 after edge N+1, i.e. 2 edges later, when there are no stalls.
  - Throughput is 1 result per cycle when out_ready is held high.
- Stall (out_ready=0 with s2 full):
  - s2 holds its data and flags.
  - If s1 is empty it accepts one more input; s1 then holds and in_ready=0.
  - Nothing is dropped, duplicated or reordered.
- Bubbles: an empty s1 never overwrites a full s2 while it is stalled. An empty s1 at an advance clears s2_valid, unless s1 is refilling it.
- Simultaneous events: an output transfer and an input transfer in the same cycle are both honoured. s1 moves to s2 and the new input loads s1.
- Data registers update only on their stage's advance with valid data, which avoids toggling while idle.
- Reset (async, any time, including mid-stall):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - out_z=0, out_zero=1, out_ones=0, out_parity=0.
  - in_ready reads 1 as soon as rst deasserts.
- Output stability: while out_valid=1 and out_ready=0, out_z and the flags must not change.
- WIDTH=1: out_zero=!out_z, out_ones=out_z, out_parity=out_z; all rules above still apply.
- Out-of-range in_op is impossible (3-bit field fully decoded).

Decomposition:
- Shared package/header logic_ops_pkg holds:
  - the op-code localparams OP_AND..OP_PASSA
  - the op-field width (3)
- One sub-module: logic_op_comb, a purely combinational WIDTH-parametrised op decoder plus function. It is instantiated once between s1 and s2.
- Flags are computed in logic_unit_pipe.

Test Plan:
- Reset then streaming, WIDTH=8, out_ready=1:
  - Stimulus: a=0xF0, b=0x3C, with ops 000..111 on consecutive cycles.
  - Required outputs, 2 edges after each input: 0x30, 0xFC, 0xCC, 0x03, 0xC0, 0xF3, 0x33, 0xF0.
  - out_valid is continuous for 8 cycles.
- Flags, WIDTH=8:
  - XOR a=0x55, b=0x55 -> z=0x00, zero=1, ones=0, parity=0.
  - NOR a=0, b=0 -> z=0xFF, ones=1, parity=0.
  - PASS_A a=0x01 -> parity=1, zero=0.
- Backpressure:
  - Stimulus: hold out_ready=0 and present 3 inputs back to back.
  - Required: first two accepted, then in_ready=0; out_z stays stable.
  - Then raise out_ready: results emerge in order; the third input is accepted the same cycle the first result leaves.
- Alternating out_ready (1,0,1,0…) with continuous in_valid:
  - No loss or duplication: the output sequence equals the input sequence.
  - A scoreboard checks 100 random ops.
- Async reset mid-stall:
  - Stimulus: assert rst between clock edges while s1 and s2 are full.
  - Required: out_valid=0 and out_z=0 immediately, without waiting for a clock edge; in_ready=1 after deassert.
  - The first post-reset input appears 2 edges later.
- Parametric sweep:
  - WIDTH=1 and WIDTH=64 with random operands per op.
  - The result matches the reference model, and the flags are consistent with the rules above.
